// File: rtl/atm_session_ctrl.sv
// atm_session_ctrl: card session FSM with PIN check, lockout, inactivity timeout and balance updates
module atm_session_ctrl #(
  parameter int W         = 4,
  parameter int MAX_TRIES = 3,
  parameter int TIMEOUT   = 15
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         card_in,
  input  logic [W-1:0] bal,
  input  logic [W-1:0] prefed,
  input  logic         pin_valid,
  input  logic [W-1:0] pin,
  input  logic         txn_valid,
  input  logic [1:0]   sel,
  input  logic [W-1:0] amt,
  output logic [W-1:0] balance,
  output logic         pin_ok,
  output logic [2:0]   tries,
  output logic         locked,
  output logic         wd_fail,
  output logic         dep_fail,
  output logic         txn_done,
  output logic         timeout,
  output logic         busy
);
  typedef enum logic [2:0] {IDLE, PIN_WAIT, MENU, EXEC, LOCKED} state_t;
  state_t state_q, state_d;
  logic [W-1:0] bal_q, bal_d, amt_q, amt_d;
  logic [1:0] sel_q, sel_d;
  logic [2:0] tries_q, tries_d;
  logic [7:0] idle_q, idle_d;
  logic pin_ok_q, pin_ok_d, locked_q, locked_d, card_q;
  logic wd_fail_q, wd_fail_d, dep_fail_q, dep_fail_d;
  logic txn_done_q, txn_done_d, timeout_q, timeout_d;
  logic [W:0] sum;
  logic stale;
  assign sum = {1'b0, bal_q} + {1'b0, amt_q};
  assign stale = (idle_q + 8'd1) == 8'(TIMEOUT);
  assign balance = bal_q;
  assign pin_ok = pin_ok_q;
  assign tries = tries_q;
  assign locked = locked_q;
  assign wd_fail = wd_fail_q;
  assign dep_fail = dep_fail_q;
  assign txn_done = txn_done_q;
  assign timeout = timeout_q;
  assign busy = (state_q != IDLE) && (state_q != LOCKED);
  // next-state and output decode; card removal wins over strobes, strobes win over timeout
  always_comb begin
    state_d = state_q;
    bal_d = bal_q;
    amt_d = amt_q;
    sel_d = sel_q;
    tries_d = tries_q;
    idle_d = idle_q;
    pin_ok_d = pin_ok_q;
    locked_d = locked_q;
    wd_fail_d = 1'b0;
    dep_fail_d = 1'b0;
    txn_done_d = 1'b0;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: if (card_in && !card_q) begin
        bal_d = bal;
        tries_d = '0;
        idle_d = '0;
        state_d = PIN_WAIT;
      end
      PIN_WAIT, MENU: if (!card_in) begin
        pin_ok_d = 1'b0;
        state_d = IDLE;
      end else if (state_q == PIN_WAIT && pin_valid) begin
        idle_d = '0;
        if (pin == prefed) begin
          pin_ok_d = 1'b1;
          tries_d = '0;
          state_d = MENU;
        end else begin
          tries_d = tries_q + 3'd1;
          if (tries_d == 3'(MAX_TRIES)) begin
            locked_d = 1'b1;
            state_d = LOCKED;
          end
        end
      end else if (state_q == MENU && txn_valid) begin
        idle_d = '0;
        if (sel == 2'b11) begin
          txn_done_d = 1'b1;
          pin_ok_d = 1'b0;
          state_d = IDLE;
        end else begin
          sel_d = sel;
          amt_d = amt;
          state_d = EXEC;
        end
      end else if (stale) begin
        timeout_d = 1'b1;
        pin_ok_d = 1'b0;
        state_d = IDLE;
      end else begin
        idle_d = idle_q + 8'd1;
      end
      EXEC: begin
        idle_d = '0;
        state_d = card_in ? MENU : IDLE;
        pin_ok_d = card_in;
        txn_done_d = card_in;
        if (sel_q == 2'b00) begin
          if (sum[W]) dep_fail_d = card_in;
          else bal_d = sum[W-1:0];
        end
        if (sel_q == 2'b01) begin
          if (bal_q >= amt_q) bal_d = bal_q - amt_q;
          else wd_fail_d = card_in;
        end
      end
      default: ;
    endcase
  end
  // state and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      bal_q <= '0;
      amt_q <= '0;
      sel_q <= '0;
      tries_q <= '0;
      idle_q <= '0;
      pin_ok_q <= 1'b0;
      locked_q <= 1'b0;
      card_q <= 1'b0;
      wd_fail_q <= 1'b0;
      dep_fail_q <= 1'b0;
      txn_done_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      bal_q <= bal_d;
      amt_q <= amt_d;
      sel_q <= sel_d;
      tries_q <= tries_d;
      idle_q <= idle_d;
      pin_ok_q <= pin_ok_d;
      locked_q <= locked_d;
      card_q <= card_in;
      wd_fail_q <= wd_fail_d;
      dep_fail_q <= dep_fail_d;
      txn_done_q <= txn_done_d;
      timeout_q <= timeout_d;
    end
  end
endmodule
